// File: rtl/zigzag_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// zigzag_block_sequencer_if
//
// Purpose: bundles the row-side and block-side handshakes of the zigzag
// block sequencer together with the buffer control strobes.
//
// Signals:
//   row_valid          upstream row available               (env -> seq)
//   row_ready          sequencer accepts a row this cycle    (seq -> env)
//   matrix_row         row index to the buffer, 0..ROWS-1    (seq -> env)
//   input_data_enable  row write strobe to the buffer        (seq -> env)
//   zigzag_enable      single-cycle zigzag/difference pulse  (seq -> env)
//   block_valid        zigzag block output valid             (seq -> env)
//   block_ready        downstream accepts the block          (env -> seq)
//   block_index        index of the current block in frame   (seq -> env)
//   last_block         current block is the final one        (seq -> env)
//
// Modports:
//   master  the sequencer side
//   slave   the upstream producer / buffer / downstream consumer side
// ---------------------------------------------------------------------------
interface zigzag_block_sequencer_if #(
    parameter int BLK_W = 16
) ();

    logic             row_valid;
    logic             row_ready;
    logic [7:0]       matrix_row;
    logic             input_data_enable;
    logic             zigzag_enable;
    logic             block_valid;
    logic             block_ready;
    logic [BLK_W-1:0] block_index;
    logic             last_block;

    modport master (
        input  row_valid,
        input  block_ready,
        output row_ready,
        output matrix_row,
        output input_data_enable,
        output zigzag_enable,
        output block_valid,
        output block_index,
        output last_block
    );

    modport slave (
        output row_valid,
        output block_ready,
        input  row_ready,
        input  matrix_row,
        input  input_data_enable,
        input  zigzag_enable,
        input  block_valid,
        input  block_index,
        input  last_block
    );

endinterface

// File: rtl/zigzag_block_sequencer.sv
// ---------------------------------------------------------------------------
// zigzag_block_sequencer
//
// Purpose: control-path sequencer for the 8x8 zigzag row buffer and its
// DC-difference stage. One block of ROWS rows is accepted from upstream,
// written into the buffer, the zigzag/difference stage is triggered once the
// buffer write latency has elapsed, and after the zigzag latency the block is
// offered downstream. Blocks are counted per frame and a one-cycle frame_done
// pulse marks the handshake of the final block.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high reset
//   start_frame   pulse, arms the sequencer for a new frame (IDLE only)
//   frame_blocks  blocks in the frame, sampled on an accepted start_frame
//   bus           zigzag_block_sequencer_if.master (row/block handshakes,
//                 buffer row index and strobes, block index / last flag)
//   frame_done    one-cycle pulse after the last block is accepted
//   busy          high in every state except IDLE
//   start_err     sticky flag, start_frame seen outside IDLE
// ---------------------------------------------------------------------------
module zigzag_block_sequencer #(
    parameter int ROWS   = 8,
    parameter int WR_LAT = 3,
    parameter int ZZ_LAT = 3,
    parameter int BLK_W  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_frame,
    input  logic [BLK_W-1:0]           frame_blocks,
    zigzag_block_sequencer_if.master   bus,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       start_err
);

    // Wait counters are loaded with LAT-1 so that the state holding the
    // counter lasts exactly LAT cycles (it leaves when the counter reads 0).
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0] WR_LOAD  = 8'(WR_LAT - 1);
    localparam logic [7:0] ZZ_LOAD  = 8'(ZZ_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ZIGZAG = 3'd3,
        ST_WAIT   = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [7:0]       row_cnt_r;
    logic [7:0]       row_cnt_s;
    logic [7:0]       wait_cnt_r;
    logic [7:0]       wait_cnt_s;
    logic [BLK_W-1:0] block_index_r;
    logic [BLK_W-1:0] block_index_s;
    logic [BLK_W-1:0] frame_blocks_r;
    logic [BLK_W-1:0] frame_blocks_s;

    logic             row_ready_r;
    logic             row_ready_s;
    logic             zigzag_enable_r;
    logic             zigzag_enable_s;
    logic             block_valid_r;
    logic             block_valid_s;
    logic             last_block_r;
    logic             last_block_s;
    logic             busy_r;
    logic             busy_s;
    logic             frame_done_r;
    logic             frame_done_s;
    logic             start_err_r;
    logic             start_err_s;

    logic             accept_s;
    logic             handshake_s;
    logic             is_last_s;

    // Handshake qualifiers; both ready/valid sides are registered flags.
    assign accept_s    = bus.row_valid & row_ready_r;
    assign handshake_s = bus.block_ready & block_valid_r;
    assign is_last_s   = (block_index_r == (frame_blocks_r - BLK_W'(1'b1)));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_frame) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && (row_cnt_r == ROW_LAST)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (wait_cnt_r == 8'd0) begin
                    state_s = ST_ZIGZAG;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_ZIGZAG: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_r == 8'd0) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                // No new row is taken before this block is handshaken: the
                // difference stage predicts DC from the previous block.
                if (handshake_s) begin
                    if (is_last_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; every output is registered from these.
    always_comb begin
        row_cnt_s      = row_cnt_r;
        wait_cnt_s     = wait_cnt_r;
        block_index_s  = block_index_r;
        frame_blocks_s = frame_blocks_r;
        start_err_s    = start_err_r;
        frame_done_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_frame) begin
                    // A zero-length frame is run as a single block.
                    if (frame_blocks == {BLK_W{1'b0}}) begin
                        frame_blocks_s = BLK_W'(1'b1);
                    end else begin
                        frame_blocks_s = frame_blocks;
                    end
                    block_index_s = {BLK_W{1'b0}};
                    start_err_s   = 1'b0;
                    row_cnt_s     = 8'd0;
                end else begin
                    row_cnt_s = 8'd0;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (row_cnt_r == ROW_LAST) begin
                        row_cnt_s  = 8'd0;
                        wait_cnt_s = WR_LOAD;
                    end else begin
                        row_cnt_s = row_cnt_r + 8'd1;
                    end
                end else begin
                    row_cnt_s = row_cnt_r;
                end
            end
            ST_DRAIN: begin
                if (wait_cnt_r != 8'd0) begin
                    wait_cnt_s = wait_cnt_r - 8'd1;
                end else begin
                    wait_cnt_s = 8'd0;
                end
            end
            ST_ZIGZAG: begin
                wait_cnt_s = ZZ_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt_r != 8'd0) begin
                    wait_cnt_s = wait_cnt_r - 8'd1;
                end else begin
                    wait_cnt_s = 8'd0;
                end
            end
            ST_OUT: begin
                if (handshake_s) begin
                    if (is_last_s) begin
                        frame_done_s = 1'b1;
                    end else begin
                        block_index_s = block_index_r + BLK_W'(1'b1);
                    end
                end else begin
                    block_index_s = block_index_r;
                end
            end
            default: begin
                row_cnt_s  = 8'd0;
                wait_cnt_s = 8'd0;
            end
        endcase

        // A start request while a frame is running does not disturb it but
        // is flagged until the next accepted start or reset.
        if (start_frame && (state_r != ST_IDLE)) begin
            start_err_s = 1'b1;
        end else begin
            start_err_s = start_err_s;
        end

        // Flags are decoded from the upcoming state so they are registered
        // and valid in the very first cycle of that state.
        row_ready_s     = (state_s == ST_FILL);
        zigzag_enable_s = (state_s == ST_ZIGZAG);
        block_valid_s   = (state_s == ST_OUT);
        busy_s          = (state_s != ST_IDLE);
        last_block_s    = (state_s != ST_IDLE) &&
                          (block_index_s == (frame_blocks_s - BLK_W'(1'b1)));
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt_r       <= 8'd0;
            wait_cnt_r      <= 8'd0;
            block_index_r   <= {BLK_W{1'b0}};
            frame_blocks_r  <= {BLK_W{1'b0}};
            row_ready_r     <= 1'b0;
            zigzag_enable_r <= 1'b0;
            block_valid_r   <= 1'b0;
            last_block_r    <= 1'b0;
            busy_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            start_err_r     <= 1'b0;
        end else begin
            row_cnt_r       <= row_cnt_s;
            wait_cnt_r      <= wait_cnt_s;
            block_index_r   <= block_index_s;
            frame_blocks_r  <= frame_blocks_s;
            row_ready_r     <= row_ready_s;
            zigzag_enable_r <= zigzag_enable_s;
            block_valid_r   <= block_valid_s;
            last_block_r    <= last_block_s;
            busy_r          <= busy_s;
            frame_done_r    <= frame_done_s;
            start_err_r     <= start_err_s;
        end
    end

    assign bus.row_ready         = row_ready_r;
    assign bus.matrix_row        = row_cnt_r;
    assign bus.input_data_enable = accept_s;
    assign bus.zigzag_enable     = zigzag_enable_r;
    assign bus.block_valid       = block_valid_r;
    assign bus.block_index       = block_index_r;
    assign bus.last_block        = last_block_r;
    assign frame_done            = frame_done_r;
    assign busy                  = busy_r;
    assign start_err             = start_err_r;

endmodule

// File: tb/tb_zigzag_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_zigzag_block_sequencer
//
// Self-checking bench: a transaction-level model (rows accepted per block,
// cycles elapsed since the last row, block/frame counters) predicts every
// output each cycle; directed scenarios add literal timing expectations and
// randomized frames exercise gaps, back-pressure, stray starts and resets.
// ---------------------------------------------------------------------------
module tb_zigzag_block_sequencer;

    localparam int ROWS    = 8;
    localparam int WR_LAT  = 3;
    localparam int ZZ_LAT  = 3;
    localparam int BLK_W   = 16;
    // Cycles after the last row accept at which zigzag fires / block shows.
    localparam int ZZ_T    = WR_LAT + 1;
    localparam int VALID_T = WR_LAT + 1 + ZZ_LAT + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_frame = 1'b0;
    logic [BLK_W-1:0] frame_blocks = '0;
    logic             frame_done;
    logic             busy;
    logic             start_err;

    zigzag_block_sequencer_if #(.BLK_W(BLK_W)) bus ();

    zigzag_block_sequencer #(
        .ROWS(ROWS), .WR_LAT(WR_LAT), .ZZ_LAT(ZZ_LAT), .BLK_W(BLK_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_frame(start_frame),
        .frame_blocks(frame_blocks),
        .bus(bus),
        .frame_done(frame_done),
        .busy(busy),
        .start_err(start_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    bit chk_en = 1'b0;

    // event log for directed expectations
    int ide_cnt, hs_cnt, fd_cnt, zz_rel, bv_rel, fd_rel;
    bit bv_last;
    int mrow_log[$];
    int bidx_hs[$];

    // behavioural model state
    bit m_active, m_err, m_done;
    int m_fb, m_bidx, m_rows, m_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: advances on each clock edge from the same inputs the DUT sees.
    always @(posedge clock) begin
        bit was, valid_now;
        if (reset) begin
            m_active = 1'b0; m_err = 1'b0; m_done = 1'b0;
            m_fb = 0; m_bidx = 0; m_rows = 0; m_t = 0;
        end else begin
            was       = m_active;
            valid_now = was && (m_rows == ROWS) && (m_t >= VALID_T);
            m_done    = 1'b0;
            if (start_frame && !was) begin
                m_active = 1'b1;
                m_fb     = (frame_blocks == 0) ? 1 : int'(frame_blocks);
                m_bidx   = 0;
                m_err    = 1'b0;
                m_rows   = 0;
                m_t      = 0;
            end else if (start_frame) begin
                m_err = 1'b1;
            end
            if (was) begin
                if (m_rows < ROWS) begin
                    if (bus.row_valid) begin
                        m_rows++;
                        m_t = 1;
                    end
                end else if (valid_now) begin
                    if (bus.block_ready) begin
                        m_rows = 0;
                        m_t    = 0;
                        if (m_bidx == m_fb - 1) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end else begin
                            m_bidx++;
                        end
                    end
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Compare process: every cycle, 3 time units after the edge.
    always @(posedge clock) begin
        bit exp_rr;
        cyc++;
        #3;
        if (chk_en) begin
            exp_rr = m_active && (m_rows < ROWS);
            check("busy",              busy,                  m_active);
            check("row_ready",         bus.row_ready,         exp_rr);
            check("matrix_row",        bus.matrix_row,        exp_rr ? m_rows : 0);
            check("input_data_enable", bus.input_data_enable, bus.row_valid && exp_rr);
            check("zigzag_enable",     bus.zigzag_enable,
                  m_active && (m_rows == ROWS) && (m_t == ZZ_T));
            check("block_valid",       bus.block_valid,
                  m_active && (m_rows == ROWS) && (m_t >= VALID_T));
            check("block_index",       bus.block_index,       m_bidx);
            check("last_block",        bus.last_block,        m_active && (m_bidx == m_fb - 1));
            check("frame_done",        frame_done,            m_done);
            check("start_err",         start_err,             m_err);

            if (bus.input_data_enable) begin
                ide_cnt++;
                mrow_log.push_back(int'(bus.matrix_row));
            end
            if (bus.block_valid && bus.block_ready) begin
                hs_cnt++;
                bidx_hs.push_back(int'(bus.block_index));
            end
            if (bus.zigzag_enable && zz_rel < 0) zz_rel = cyc - start_cyc;
            if (bus.block_valid && bv_rel < 0) begin
                bv_rel  = cyc - start_cyc;
                bv_last = bus.last_block;
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_rel < 0) fd_rel = cyc - start_cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_frame(input int fb);
        frame_blocks = BLK_W'(fb);
        start_frame  = 1'b1;
        start_cyc    = cyc;
        ide_cnt = 0; hs_cnt = 0; fd_cnt = 0;
        zz_rel = -1; bv_rel = -1; fd_rel = -1; bv_last = 1'b0;
        mrow_log.delete();
        bidx_hs.delete();
        tick();
        start_frame = 1'b0;
    endtask

    // rv_mode: 0 high, 1 toggle, 2 random (+ stray starts/noise/resets)
    // br_mode: 0 high, 1 low, 2 random
    task automatic drive_cycle(input int rv_mode, input int br_mode);
        case (rv_mode)
            0:       bus.row_valid = 1'b1;
            1:       bus.row_valid = ~bus.row_valid;
            default: bus.row_valid = ($urandom_range(0, 99) < 55);
        endcase
        case (br_mode)
            0:       bus.block_ready = 1'b1;
            1:       bus.block_ready = 1'b0;
            default: bus.block_ready = ($urandom_range(0, 99) < 50);
        endcase
        if (rv_mode == 2) begin
            start_frame  = ($urandom_range(0, 99) < 3);
            frame_blocks = BLK_W'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
        end
        tick();
    endtask

    task automatic wait_idle(input int rv_mode, input int br_mode, input string name);
        int n = 0;
        do begin
            drive_cycle(rv_mode, br_mode);
            n++;
        end while (busy && n < 2000);
        check({name, "_idle_in_budget"}, busy, 0);
        start_frame     = 1'b0;
        reset           = 1'b0;
        bus.row_valid   = 1'b0;
        bus.block_ready = 1'b0;
        tick();
    endtask

    initial begin
        bus.row_valid   = 1'b0;
        bus.block_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // 1: single block, continuous valid/ready, exact timing
        begin_frame(1);
        wait_idle(0, 0, "t1");
        check("t1_ide_pulses",   ide_cnt, 8);
        check("t1_zigzag_cycle", zz_rel, 12);
        check("t1_valid_cycle",  bv_rel, 16);
        check("t1_last_block",   bv_last, 1);
        check("t1_done_cycle",   fd_rel, 17);
        check("t1_done_count",   fd_cnt, 1);

        // 2: three blocks, row_valid toggling
        begin_frame(3);
        wait_idle(1, 0, "t2");
        check("t2_ide_pulses", ide_cnt, 24);
        check("t2_handshakes", bidx_hs.size(), 3);
        for (int i = 0; i < mrow_log.size(); i++) check("t2_row_seq", mrow_log[i], i % 8);
        for (int i = 0; i < bidx_hs.size(); i++) check("t2_block_idx", bidx_hs[i], i);

        // 3: back-pressure for 10 cycles in OUT
        begin_frame(2);
        begin
            int n = 0;
            do begin
                bus.row_valid = 1'b1; bus.block_ready = 1'b0;
                tick();
                n++;
            end while (!bus.block_valid && n < 40);
        end
        check("t3_reached_out", bus.block_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", bus.block_valid, 1);
            check("t3_hold_index", bus.block_index, 0);
            check("t3_hold_rready", bus.row_ready, 0);
        end
        wait_idle(0, 0, "t3");
        check("t3_handshakes", hs_cnt, 2);
        check("t3_resume_row0", (mrow_log.size() > 8) ? mrow_log[8] : -1, 0);

        // 4: stray start during DRAIN
        begin_frame(1);
        for (int i = 0; i < 9; i++) drive_cycle(0, 0);
        start_frame = 1'b1;
        drive_cycle(0, 0);
        start_frame = 1'b0;
        wait_idle(0, 0, "t4");
        check("t4_zigzag_cycle", zz_rel, 12);
        check("t4_valid_cycle",  bv_rel, 16);
        check("t4_start_err",    start_err, 1);
        begin_frame(1);
        check("t4_err_cleared",  start_err, 0);
        wait_idle(0, 0, "t4b");

        // 5: reset after row 4 of a block
        begin_frame(2);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0);
        reset = 1'b1;
        tick();
        check("t5_busy",       busy, 0);
        check("t5_row_ready",  bus.row_ready, 0);
        check("t5_matrix_row", bus.matrix_row, 0);
        check("t5_ide",        bus.input_data_enable, 0);
        check("t5_block_idx",  bus.block_index, 0);
        reset = 1'b0;
        tick();
        begin_frame(1);
        wait_idle(0, 0, "t5");
        check("t5_restart_row0", (mrow_log.size() > 0) ? mrow_log[0] : -1, 0);
        check("t5_restart_idx",  (bidx_hs.size() > 0) ? bidx_hs[0] : -1, 0);

        // 6: frame_blocks = 0 behaves as one block
        begin_frame(0);
        wait_idle(0, 0, "t6");
        check("t6_handshakes", hs_cnt, 1);
        check("t6_done_count", fd_cnt, 1);
        check("t6_last_block", bv_last, 1);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            begin_frame(int'($urandom_range(0, 4)));
            wait_idle(2, 2, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
